mult_seq_ctrl: RTL and testbench

//   Sequential shift-and-add multiplier: an FSM controller plus a datapath that

---
 rtl/mult_seq_ctrl_if.sv | 27 ++
 rtl/mult_seq_ctrl.sv | 113 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Handshake bundle between an upstream sequencer and the sequential multiplier.
//   start : request, sampled by the multiplier only while idle
//   X, Y  : N-bit operands, captured on the accepted start edge
//   busy  : operation in progress (CALC or DONE)
//   done  : one-cycle pulse, P carries the new product in that cycle
//   P     : 2N-bit product register, held until the next done
// master modport = sequencer side, slave modport = multiplier side.
interface mult_seq_ctrl_if #(
  parameter int unsigned N = 3
);
  logic             start;
  logic [N-1:0]     X;
  logic [N-1:0]     Y;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   P;

  modport master (
    output start, X, Y,
    input  busy, done, P
  );

  modport slave (
    input  start, X, Y,
    output busy, done, P
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier.
// One N-bit ripple-carry adder is reused over N iterations; an
// IDLE -> CALC -> DONE controller sequences the operation.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset (aborts any operation, clears P)
//   bus : mult_seq_ctrl_if.slave -- start/X/Y in, busy/done/P out
// Timing: accept on edge k, N iterations on edges k+1..k+N, done=1 in the
// cycle after edge k+N, back to IDLE on the following edge.
module mult_seq_ctrl #(
  parameter int unsigned N = 3
) (
  input  logic            clk,
  input  logic            rst,
  mult_seq_ctrl_if.slave  bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * N;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_M;      // latched multiplicand
  logic [N-1:0]    r_Q;      // multiplier, shifts out LSB-first, fills with product low bits
  logic [N-1:0]    r_acc;    // accumulator (its extra top bit is always zero after a shift, so not stored)
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_P;
  logic            r_busy;
  logic            r_done;

  logic [N-1:0]    w_addend;
  logic [N-1:0]    w_sum;
  logic            w_cout;
  logic [PW-1:0]   w_aq_nxt; // {acc,Q} after this iteration's add and shift
  logic            w_last;

  // Single N-bit ripple-carry adder: acc + (Q[0] ? M : 0).
  always_comb begin : adder
    logic v_c;
    w_addend = r_Q[0] ? r_M : '0;
    w_sum    = '0;
    v_c      = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      w_sum[i] = r_acc[i] ^ w_addend[i] ^ v_c;
      v_c      = (r_acc[i] & w_addend[i]) | (v_c & (r_acc[i] ^ w_addend[i]));
    end
    w_cout = v_c;
  end

  // {c,sum,Q} >> 1; the carry lands in the accumulator MSB so nothing is lost.
  assign w_aq_nxt = PW'({w_cout, w_sum, r_Q} >> 1);
  assign w_last   = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_M     <= '0;
      r_Q     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_P     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_M     <= bus.X;
            r_Q     <= bus.Y;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_CALC: begin
          r_acc <= w_aq_nxt[PW-1:N];
          r_Q   <= w_aq_nxt[N-1:0];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // P is loaded from the final iteration's result on the edge entering DONE.
            r_P     <= w_aq_nxt;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.P    = r_P;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl (N=3).
// Reference model: an operation timeline (cycles since accept) plus the
// arithmetic product X*Y; busy/done/P are checked after every clock edge.
module tb_mult_seq_ctrl;

  localparam int unsigned N    = 3;
  localparam int unsigned MASK = (1 << N) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.N(N)) bus ();

  mult_seq_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model state
  int unsigned m_t    = 0;   // 0 = idle, else cycles since accept
  int unsigned m_prod = 0;
  int unsigned m_P    = 0;
  int unsigned cyc    = 0;
  string       phase  = "init";

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s got %0d expected %0d (cycle %0d)", phase, tag, got, exp, cyc);
    end
  endtask

  // Drive inputs, clock once, advance the model, then check all outputs.
  task automatic step(input logic s, input int unsigned x, input int unsigned y, input logic r);
    int unsigned xm, ym;
    xm = x & MASK;
    ym = y & MASK;
    bus.start = s;
    bus.X     = xm[N-1:0];
    bus.Y     = ym[N-1:0];
    rst       = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_t = 0;
      m_P = 0;
    end else if (m_t == 0) begin
      if (s) begin
        m_t    = 1;
        m_prod = xm * ym;
      end
    end else begin
      m_t++;
      if (m_t == N + 1) m_P = m_prod;
      if (m_t == N + 2) m_t = 0;
    end
    #1;
    check("busy", longint'(bus.busy), longint'(m_t != 0));
    check("done", longint'(bus.done), longint'(m_t == N + 1));
    check("P",    longint'(bus.P),    longint'(m_P));
  endtask

  // One isolated operation; operands are scrambled while busy.
  task automatic run_op(input int unsigned x, input int unsigned y, input int unsigned exp_p);
    int unsigned lat;
    step(1'b1, x, y, 1'b0);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      step(1'b0, $urandom, $urandom, 1'b0);
      lat++;
    end
    check("latency", lat, N + 1);
    check("product", longint'(bus.P), exp_p);
    step(1'b0, 0, 0, 1'b0);
    check("busy_fall", longint'(bus.busy), 0);
    check("P_hold", longint'(bus.P), exp_p);
  endtask

  initial begin
    int unsigned ndone;
    int unsigned pd;
    int unsigned last_done;
    bit          have_last;

    // 1. reset (second edge also has start=1: reset wins)
    phase = "reset";
    step(1'b0, 0, 0, 1'b1);
    step(1'b1, 5, 5, 1'b1);
    check("busy_rst", longint'(bus.busy), 0);
    check("done_rst", longint'(bus.done), 0);
    check("P_rst",    longint'(bus.P), 0);
    step(1'b0, 0, 0, 1'b0);

    // 2./3. basic products and boundaries
    phase = "op_5x7"; run_op(5, 7, 35);
    phase = "op_7x7"; run_op(7, 7, 49);
    phase = "op_0x6"; run_op(0, 6, 0);
    phase = "op_6x0"; run_op(6, 0, 0);

    // 4. start pulsed during CALC is ignored
    phase = "ignore_start";
    step(1'b1, 3, 2, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 7, 7, 1'b0);
    ndone = 0;
    pd    = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 7, 7, 1'b0);
      if (bus.done === 1'b1) begin
        ndone++;
        pd = bus.P;
      end
    end
    check("one_done", ndone, 1);
    check("done_P", pd, 6);

    // 5. reset mid-operation aborts it
    phase = "abort";
    step(1'b1, 7, 5, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 0, 0, 1'b0);
      if (bus.done === 1'b1) ndone++;
    end
    check("no_done", ndone, 0);
    check("P_cleared", longint'(bus.P), 0);
    run_op(2, 3, 6);

    // 6. exhaustive, start held high
    phase = "exhaustive";
    have_last = 1'b0;
    last_done = 0;
    for (int unsigned x = 0; x <= MASK; x++) begin
      for (int unsigned y = 0; y <= MASK; y++) begin
        ndone = 0;
        step(1'b1, x, y, 1'b0);
        for (int unsigned k = 0; k < N + 1; k++) begin
          step(1'b1, $urandom, $urandom, 1'b0);
          if (bus.done === 1'b1) begin
            ndone++;
            check("xy_prod", longint'(bus.P), x * y);
            if (have_last) check("period", cyc - last_done, N + 2);
            last_done = cyc;
            have_last = 1'b1;
          end
        end
        check("xy_done", ndone, 1);
      end
    end

    // 7. random traffic with occasional reset
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(2, 0) == 0), $urandom, $urandom, ($urandom_range(39, 0) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
